// File: rtl/uart_tx_if.sv
// Read-side handshake between the transmitter and its lookahead TX FIFO.
interface uart_tx_if;
  logic       fifo_not_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;

  modport master (
    input  fifo_not_empty,
    input  fifo_data,
    output fifo_read
  );

  modport slave (
    output fifo_not_empty,
    output fifo_data,
    input  fifo_read
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a lookahead FIFO and frames them as
// start + 8 data (LSB first) + optional parity + 1/2 stop bits.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      enable,
  uart_tx_if.master fifo,
  output logic      tx,
  output logic      busy,
  output logic      frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  localparam logic [15:0] LP_RELOAD    = 16'(CLKS_PER_BIT - 1);
  localparam logic        LP_LAST_STOP = (STOP_BITS == 2);
  localparam logic        LP_PAR_INIT  = (PARITY == 2);
  localparam logic        LP_HAS_PAR   = (PARITY != 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_shift;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic        r_stop_idx;
  logic        r_par;

  logic        r_tx;
  logic        r_busy;
  logic        r_fifo_read;
  logic        r_frame_done;

  logic        w_tx_nxt;
  logic        w_busy_nxt;
  logic        w_read_nxt;
  logic        w_done_nxt;
  logic        w_bit_end;
  logic        w_last_stop;
  logic        w_capture;

  assign w_bit_end   = (r_baud_cnt == '0);
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_idx == LP_LAST_STOP);
  // A new byte may be taken from idle or straight off the final stop-bit cycle.
  assign w_capture   = enable && fifo.fifo_not_empty && ((r_state == S_IDLE) || w_last_stop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_fifo_read  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= w_busy_nxt;
      r_fifo_read  <= w_read_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_state_nxt = S_START;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = LP_HAS_PAR ? S_PAR : S_STOP;
      S_PAR:   if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP:  if (w_last_stop) w_state_nxt = w_capture ? S_START : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line lags state by one cycle.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = (r_state != S_IDLE);
    w_read_nxt = w_capture;
    w_done_nxt = w_last_stop;
    case (r_state)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = r_shift[0];
      S_PAR:   w_tx_nxt = r_par;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par      <= 1'b0;
    end else if (w_capture) begin
      r_shift    <= fifo.fifo_data;
      r_baud_cnt <= LP_RELOAD;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par      <= LP_PAR_INIT;
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_baud_cnt <= LP_RELOAD;
        if (r_state == S_DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_par     <= r_par ^ r_shift[0];
          r_bit_idx <= r_bit_idx + 3'd1;
        end
        if (r_state == S_STOP) begin
          r_stop_idx <= w_last_stop ? 1'b0 : (r_stop_idx + 1'b1);
        end
      end else begin
        r_baud_cnt <= r_baud_cnt - 16'd1;
      end
    end
  end

  assign tx             = r_tx;
  assign busy           = r_busy;
  assign frame_done     = r_frame_done;
  assign fifo.fifo_read = r_fifo_read;

endmodule

// File: tb/tb_uart_tx.sv
// Three transmitters (no parity/1 stop, even/2 stop, odd/1 stop) at 4 clocks
// per bit, each fed from a queue-backed FIFO and checked against a frame model.
module tb_uart_tx;

  localparam int LP_CPB = 4;

  typedef logic [127:0] wave_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic [2:0] fne;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [2:0] rd_w;
  logic [7:0] fdat [3];

  byte unsigned fq [3][$];
  logic s_tx   [3][$];
  logic s_busy [3][$];
  logic s_rd   [3][$];
  logic s_done [3][$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    uart_tx_if u_if ();
    assign u_if.fifo_not_empty = fne[g];
    assign u_if.fifo_data      = fdat[g];
    assign rd_w[g]             = u_if.fifo_read;

    uart_tx #(
      .CLKS_PER_BIT(LP_CPB),
      .PARITY      (g),
      .STOP_BITS   ((g == 1) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .enable    (en[g]),
      .fifo      (u_if),
      .tx        (tx_w[g]),
      .busy      (busy_w[g]),
      .frame_done(done_w[g])
    );
  end

  // FIFO model: pop on a sampled read pulse, present the new head by the next edge.
  always @(posedge clk) begin
    for (int l = 0; l < 3; l++)
      if (rd_w[l] === 1'b1 && fq[l].size() != 0) void'(fq[l].pop_front());
  end

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      fne[l]  <= (fq[l].size() != 0);
      fdat[l] <= (fq[l].size() != 0) ? fq[l][0] : 8'h00;
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (rd_w[l] === 1'b1) begin
        n_cmp++;
        if (fne[l] !== 1'b1) begin
          n_err++;
          $display("FAIL rd_without_data lane%0d: fifo_not_empty=%b required 1", l, fne[l]);
        end
      end
    end
  end

  function automatic int frame_len(input int l);
    return LP_CPB * (9 + ((l != 0) ? 1 : 0) + ((l == 1) ? 2 : 1));
  endfunction

  // Expected line level per cycle, bit k = k cycles after the start-bit fall.
  function automatic wave_t exp_wave(input int l, input logic [7:0] b);
    logic  bits[$];
    wave_t w = '0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (l == 1) bits.push_back(^b);
    if (l == 2) bits.push_back(~^b);
    for (int i = 0; i < ((l == 1) ? 2 : 1); i++) bits.push_back(1'b1);
    for (int k = 0; k < bits.size() * LP_CPB; k++) w[k] = bits[k / LP_CPB];
    return w;
  endfunction

  function automatic logic smp(input int l, input int kind, input int i);
    if (i < 0 || i >= s_tx[l].size()) return 1'bx;
    case (kind)
      0:       return s_tx[l][i];
      1:       return s_busy[l][i];
      2:       return s_rd[l][i];
      default: return s_done[l][i];
    endcase
  endfunction

  function automatic wave_t obs_wave(input int l, input int start, input int n);
    wave_t w = '0;
    for (int k = 0; k < n; k++) w[k] = smp(l, 0, start + k);
    return w;
  endfunction

  function automatic int find_evt(input int l, input int kind, input int from);
    for (int i = from; i < s_tx[l].size(); i++) if (smp(l, kind, i) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_lvl(input int l, input int kind, input logic v, input int from);
    int c = 0;
    for (int i = from; i < s_tx[l].size(); i++) if (smp(l, kind, i) === v) c++;
    return c;
  endfunction

  task automatic capture(input int n);
    for (int l = 0; l < 3; l++) begin
      s_tx[l].delete(); s_busy[l].delete(); s_rd[l].delete(); s_done[l].delete();
    end
    repeat (n) begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        s_tx[l].push_back(tx_w[l]);
        s_busy[l].push_back(busy_w[l]);
        s_rd[l].push_back(rd_w[l]);
        s_done[l].push_back(done_w[l]);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] b;
    int tr, td;
    b = 8'($urandom);
    rst_n = 1'b0;
    en = 3'b001;
    fq[0].push_back(b);
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_w !== 3'b111) begin n_err++; $display("FAIL reset_tx: got %b required 111", tx_w); end
    n_cmp++; if (busy_w !== 3'b000) begin n_err++; $display("FAIL reset_busy: got %b required 000", busy_w); end
    n_cmp++; if (rd_w !== 3'b000) begin n_err++; $display("FAIL reset_read: got %b required 000", rd_w); end
    rst_n = 1'b1;
    capture(60);
    tr = find_evt(0, 2, 0);
    n_cmp++; if (tr !== 0) begin n_err++; $display("FAIL reset_first_read: read at sample %0d required 0", tr); end
    if (tr < 0) tr = 0;
    n_cmp++; if (smp(0, 0, tr + 1) !== 1'b0) begin n_err++; $display("FAIL reset_tx_fall: got %b required 0", smp(0, 0, tr + 1)); end
    n_cmp++;
    if (obs_wave(0, tr + 1, 40) !== exp_wave(0, b)) begin
      n_err++; $display("FAIL reset_frame byte %h: got %h required %h", b, obs_wave(0, tr + 1, 40), exp_wave(0, b));
    end
    td = find_evt(0, 3, 0);
    n_cmp++; if (td !== tr + 40) begin n_err++; $display("FAIL reset_done: at %0d required %0d", td, tr + 40); end
  endtask

  task automatic test_frame_a5();
    logic [9:0] seq;
    int tr;
    seq = 10'b1101001010;
    fq[0].push_back(8'hA5);
    capture(60);
    tr = find_evt(0, 2, 0);
    n_cmp++; if (tr < 0) begin n_err++; $display("FAIL a5_read: got none required 1 pulse"); tr = 0; end
    n_cmp++; if (smp(0, 0, tr) !== 1'b1) begin n_err++; $display("FAIL a5_idle_before: got %b required 1", smp(0, 0, tr)); end
    n_cmp++; if (smp(0, 1, tr) !== 1'b0 || smp(0, 1, tr + 1) !== 1'b1) begin
      n_err++; $display("FAIL a5_busy_rise: got %b%b required 01", smp(0, 1, tr), smp(0, 1, tr + 1));
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (smp(0, 0, tr + 1 + LP_CPB * i + 2) !== seq[i]) begin
        n_err++; $display("FAIL a5_bit%0d: got %b required %b", i, smp(0, 0, tr + 1 + LP_CPB * i + 2), seq[i]);
      end
    end
    n_cmp++; if (find_evt(0, 3, 0) !== tr + 40 || count_lvl(0, 3, 1'b1, 0) !== 1) begin
      n_err++; $display("FAIL a5_done: first at %0d count %0d required %0d count 1", find_evt(0, 3, 0), count_lvl(0, 3, 1'b1, 0), tr + 40);
    end
    n_cmp++; if (smp(0, 1, tr + 40) !== 1'b1 || smp(0, 1, tr + 41) !== 1'b0) begin
      n_err++; $display("FAIL a5_busy_fall: got %b%b required 10", smp(0, 1, tr + 40), smp(0, 1, tr + 41));
    end
  endtask

  task automatic test_back_to_back();
    int tr1, tr2;
    wave_t w;
    fq[0].push_back(8'h00);
    fq[0].push_back(8'hFF);
    capture(130);
    tr1 = find_evt(0, 2, 0);
    if (tr1 < 0) tr1 = 0;
    tr2 = find_evt(0, 2, tr1 + 1);
    n_cmp++; if (count_lvl(0, 2, 1'b1, 0) !== 2) begin n_err++; $display("FAIL b2b_reads: got %0d required 2", count_lvl(0, 2, 1'b1, 0)); end
    n_cmp++; if (tr2 - tr1 !== 40) begin n_err++; $display("FAIL b2b_spacing: got %0d required 40", tr2 - tr1); end
    w = exp_wave(0, 8'h00) | (exp_wave(0, 8'hFF) << 40);
    n_cmp++; if (obs_wave(0, tr1 + 1, 80) !== w) begin
      n_err++; $display("FAIL b2b_wave: got %h required %h", obs_wave(0, tr1 + 1, 80), w);
    end
    n_cmp++; if (smp(0, 0, tr1 + 40) !== 1'b1 || smp(0, 0, tr1 + 41) !== 1'b0) begin
      n_err++; $display("FAIL b2b_gap: got %b%b required 10", smp(0, 0, tr1 + 40), smp(0, 0, tr1 + 41));
    end
    n_cmp++; if (smp(0, 1, tr1 + 41) !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b required 1", smp(0, 1, tr1 + 41)); end
    n_cmp++; if (count_lvl(0, 3, 1'b1, 0) !== 2 || smp(0, 3, tr1 + 80) !== 1'b1) begin
      n_err++; $display("FAIL b2b_done: count %0d required 2", count_lvl(0, 3, 1'b1, 0));
    end
  endtask

  task automatic test_parity();
    logic [7:0] b;
    int tr, n;
    en[1] = 1'b1;
    en[2] = 1'b1;
    for (int it = 0; it < 4; it++) begin
      b = (it == 0) ? 8'h07 : 8'($urandom);
      fq[1].push_back(b);
      fq[2].push_back(b);
      capture(70);
      for (int l = 1; l < 3; l++) begin
        tr = find_evt(l, 2, 0);
        if (tr < 0) tr = 0;
        n = frame_len(l);
        n_cmp++; if (obs_wave(l, tr + 1, n) !== exp_wave(l, b)) begin
          n_err++; $display("FAIL parity_frame lane%0d byte %h: got %h required %h", l, b, obs_wave(l, tr + 1, n), exp_wave(l, b));
        end
        n_cmp++; if (find_evt(l, 3, 0) !== tr + n) begin
          n_err++; $display("FAIL parity_done lane%0d: at %0d required %0d", l, find_evt(l, 3, 0), tr + n);
        end
        n_cmp++; if (smp(l, 1, tr + n + 1) !== 1'b0) begin
          n_err++; $display("FAIL parity_busy_fall lane%0d: got %b required 0", l, smp(l, 1, tr + n + 1));
        end
        if (it == 0) begin
          n_cmp++; if (smp(l, 0, tr + 1 + 9 * LP_CPB + 2) !== ((l == 1) ? 1'b1 : 1'b0)) begin
            n_err++; $display("FAIL parity_bit_07 lane%0d: got %b required %b", l, smp(l, 0, tr + 1 + 9 * LP_CPB + 2), (l == 1) ? 1'b1 : 1'b0);
          end
        end
      end
    end
    en[1] = 1'b0;
    en[2] = 1'b0;
  endtask

  task automatic test_enable();
    logic [7:0] b2;
    int tr;
    b2 = 8'($urandom);
    en[0] = 1'b0;
    fq[0].push_back(8'h55);
    fq[0].push_back(b2);
    capture(6);
    n_cmp++; if (count_lvl(0, 2, 1'b1, 0) !== 0) begin n_err++; $display("FAIL en_low_read: got %0d pulses required 0", count_lvl(0, 2, 1'b1, 0)); end
    en[0] = 1'b1;
    fork
      begin
        repeat (12) @(negedge clk);
        en[0] = 1'b0;
      end
    join_none
    capture(90);
    tr = find_evt(0, 2, 0);
    if (tr < 0) tr = 0;
    n_cmp++; if (count_lvl(0, 2, 1'b1, 0) !== 1) begin n_err++; $display("FAIL en_drop_reads: got %0d required 1", count_lvl(0, 2, 1'b1, 0)); end
    n_cmp++; if (obs_wave(0, tr + 1, 40) !== exp_wave(0, 8'h55)) begin
      n_err++; $display("FAIL en_drop_frame: got %h required %h", obs_wave(0, tr + 1, 40), exp_wave(0, 8'h55));
    end
    n_cmp++; if (count_lvl(0, 0, 1'b0, tr + 41) !== 0 || count_lvl(0, 1, 1'b1, tr + 41) !== 0) begin
      n_err++; $display("FAIL en_drop_idle: low tx %0d busy %0d required 0 0", count_lvl(0, 0, 1'b0, tr + 41), count_lvl(0, 1, 1'b1, tr + 41));
    end
    en[0] = 1'b1;
    capture(60);
    tr = find_evt(0, 2, 0);
    if (tr < 0) tr = 0;
    n_cmp++; if (count_lvl(0, 2, 1'b1, 0) !== 1 || obs_wave(0, tr + 1, 40) !== exp_wave(0, b2)) begin
      n_err++; $display("FAIL en_resume byte %h: got %h required %h", b2, obs_wave(0, tr + 1, 40), exp_wave(0, b2));
    end
  endtask

  task automatic test_empty();
    en[0] = 1'b1;
    capture(100);
    n_cmp++; if (count_lvl(0, 2, 1'b1, 0) !== 0) begin n_err++; $display("FAIL empty_read: got %0d pulses required 0", count_lvl(0, 2, 1'b1, 0)); end
    n_cmp++; if (count_lvl(0, 0, 1'b1, 0) !== 100) begin n_err++; $display("FAIL empty_tx: high %0d required 100", count_lvl(0, 0, 1'b1, 0)); end
    n_cmp++; if (count_lvl(0, 1, 1'b0, 0) !== 100) begin n_err++; $display("FAIL empty_busy: low %0d required 100", count_lvl(0, 1, 1'b0, 0)); end
  endtask

  task automatic test_reset_mid();
    int k;
    int dones;
    k = 0;
    dones = 0;
    fq[0].push_back(8'($urandom));
    while (rd_w[0] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (k >= 20) begin n_err++; $display("FAIL mid_read: got no pulse required 1 within 20 cycles"); end
    repeat (18) @(negedge clk);
    n_cmp++; if (busy_w[0] !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b required 1", busy_w[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx_w[0] !== 1'b1) begin n_err++; $display("FAIL mid_async_tx: got %b required 1", tx_w[0]); end
    n_cmp++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL mid_async_busy: got %b required 0", busy_w[0]); end
    repeat (3) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) dones++;
    end
    rst_n = 1'b1;
    capture(60);
    dones += count_lvl(0, 3, 1'b1, 0);
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d pulses required 0", dones); end
    n_cmp++; if (count_lvl(0, 0, 1'b0, 0) !== 0) begin n_err++; $display("FAIL mid_idle_tx: low %0d required 0", count_lvl(0, 0, 1'b0, 0)); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_parity();
    test_enable();
    test_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
